lcd_cmd_sched: RTL and testbench

//  Sequencer for the 8-slot LCD command register bank (24-bit slots {addr[23:16],ctrl[15:8],data[7:0]}).

---
 rtl/lcd_cmd_sched_pkg.sv | 42 ++++
 rtl/lcd_cmd_sched_tmo_cnt.sv | 48 ++++
 rtl/lcd_cmd_sched.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_cmd_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_sched_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD command scheduler: default bank geometry,
// command-word field bounds, the packed command layout and the FSM state
// encoding (plain localparam constants so older tools can read them).
// ----------------------------------------------------------------------------
package lcd_pkg;

   // Default bank geometry
   localparam int SLOTS_DEF = 8;
   localparam int SEL_W_DEF = 3;
   localparam int WORD_W    = 24;

   // Command word field bounds {addr, ctrl, data}
   localparam int ADDR_HI = 23;
   localparam int ADDR_LO = 16;
   localparam int CTRL_HI = 15;
   localparam int CTRL_LO = 8;
   localparam int DATA_HI = 7;
   localparam int DATA_LO = 0;

   typedef struct packed {
      logic [ADDR_HI-ADDR_LO:0] addr;
      logic [CTRL_HI-CTRL_LO:0] ctrl;
      logic [DATA_HI-DATA_LO:0] data;
   } lcd_cmd_t;

   // Sequencer states
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SEL       = 3'd1;
   localparam logic [2:0] ST_SETTLE    = 3'd2;
   localparam logic [2:0] ST_ISSUE     = 3'd3;
   localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
   localparam logic [2:0] ST_WAIT_DONE = 3'd5;
   localparam logic [2:0] ST_FIN       = 3'd6;

   // True in the two handshake states that are guarded by the timeout
   function automatic logic is_wait_state(input logic [2:0] st);
      return (st == ST_WAIT_ACK) || (st == ST_WAIT_DONE);
   endfunction

endpackage

// File: rtl/lcd_cmd_sched_tmo_cnt.sv
// ----------------------------------------------------------------------------
// lcd_tmo_cnt
// Per-wait-state timeout counter.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   clr_i      in   force the count back to zero (has priority over en_i)
//   en_i       in   count this cycle
//   expired_o  out  high on the enabled cycle that carries the count to
//                   all-ones, so a wait state lasts at most 2**TMO_W-1 cycles
// ----------------------------------------------------------------------------
module lcd_tmo_cnt
   import lcd_pkg::*;
#(
   parameter int TMO_W = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   // One below all-ones: the count that is about to become all-ones
   localparam logic [TMO_W-1:0] LAST_C = ~TMO_W'(1);

   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
   end

   assign expired_o = en_i && (cnt_q == LAST_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lcd_cmd_sched.sv
// ----------------------------------------------------------------------------
// lcd_cmd_sched
// Sequencer for the LCD command register bank. The host loads command words
// into successive bank slots while idle; on start the slots 0..count-1 are
// replayed to the LCD driver one at a time, each handshaken on the driver's
// busy bit with a per-wait-state timeout. abort returns to idle at any time.
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   wr_en_i       in   host write strobe (idle and not full only)
//   wr_data_i     in   command word for the next free slot
//   clr_i         in   idle only: empty the list, clear error flags
//   start_i       in   idle only: replay the loaded slots
//   abort_i       in   any state: back to idle next cycle
//   lcd_status_i  in   driver status byte, bit BUSY_BIT = executing
//   ctrl_out_o    out  bank write data (bank ctrl_in)
//   sel_in_o      out  bank write slot
//   sel_out_o     out  bank read slot
//   lcd_go_o      out  one-cycle pulse: bank output holds a valid command
//   count_o       out  number of loaded slots, 0..SLOTS
//   busy_o        out  high whenever not idle
//   done_o        out  one-cycle pulse at the end of a replay
//   err_ovf_o     out  sticky: write attempted while full
//   err_tmo_o     out  sticky: handshake timeout
// ----------------------------------------------------------------------------
module lcd_cmd_sched
   import lcd_pkg::*;
#(
   parameter int SLOTS    = SLOTS_DEF,
   parameter int SEL_W    = SEL_W_DEF,
   parameter int BUSY_BIT = 0,
   parameter int TMO_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic              clr_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [7:0]        lcd_status_i,
   output logic [WORD_W-1:0] ctrl_out_o,
   output logic [SEL_W-1:0]  sel_in_o,
   output logic [SEL_W-1:0]  sel_out_o,
   output logic              lcd_go_o,
   output logic [SEL_W:0]    count_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_ovf_o,
   output logic              err_tmo_o
);

   localparam logic [SEL_W:0] FULL_C = (SEL_W+1)'(SLOTS);

   logic [2:0]       state_q,   state_d;
   logic [SEL_W-1:0] wr_ptr_q,  wr_ptr_d;
   logic [SEL_W:0]   count_q,   count_d;
   logic [SEL_W-1:0] idx_q,     idx_d;
   logic [SEL_W-1:0] sel_in_q,  sel_in_d;
   logic [SEL_W-1:0] sel_out_q, sel_out_d;
   lcd_cmd_t         ctrl_q,    ctrl_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_tmo_q, err_tmo_d;

   logic drv_busy;
   logic last_cmd;
   logic tmo_clr;
   logic tmo_en;
   logic tmo_exp;
   logic status_unused;

   assign drv_busy      = lcd_status_i[BUSY_BIT];
   assign status_unused = ^lcd_status_i;
   assign last_cmd      = ({1'b0, idx_q} == (count_q - (SEL_W+1)'(1)));

   // The timer restarts on every state change, which covers entry into
   // each wait state (including WAIT_ACK -> WAIT_DONE).
   assign tmo_clr = (state_d != state_q);
   assign tmo_en  = is_wait_state(state_q);

   lcd_tmo_cnt #(
      .TMO_W (TMO_W)
   ) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_exp)
   );

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      idx_d     = idx_q;
      sel_in_d  = sel_in_q;
      sel_out_d = sel_out_q;
      ctrl_d    = ctrl_q;
      err_ovf_d = err_ovf_q;
      err_tmo_d = err_tmo_q;

      if (abort_i) begin
         // Abort wins over everything, including idle-state commands
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_i) begin
                  count_d   = '0;
                  wr_ptr_d  = '0;
                  err_ovf_d = 1'b0;
                  err_tmo_d = 1'b0;
               end else if (start_i) begin
                  if (count_q != '0) begin
                     state_d = ST_SEL;
                     idx_d   = '0;
                  end else begin
                     state_d = ST_FIN;
                  end
               end else if (wr_en_i) begin
                  if (count_q < FULL_C) begin
                     // Bank write port sees the new word and slot together
                     ctrl_d   = lcd_cmd_t'(wr_data_i);
                     sel_in_d = wr_ptr_q;
                     wr_ptr_d = wr_ptr_q + SEL_W'(1);
                     count_d  = count_q + (SEL_W+1)'(1);
                  end else begin
                     err_ovf_d = 1'b1;
                  end
               end
            end
            ST_SEL: begin
               sel_out_d = idx_q;
               state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
               // Bank read register captures slot[sel_out] this cycle
               state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (drv_busy) begin
                  state_d = ST_WAIT_DONE;
               end else if (tmo_exp) begin
                  err_tmo_d = 1'b1;
                  state_d   = ST_FIN;
               end
            end
            ST_WAIT_DONE: begin
               if (!drv_busy) begin
                  if (last_cmd) begin
                     state_d = ST_FIN;
                  end else begin
                     idx_d   = idx_q + SEL_W'(1);
                     state_d = ST_SEL;
                  end
               end else if (tmo_exp) begin
                  err_tmo_d = 1'b1;
                  state_d   = ST_FIN;
               end
            end
            ST_FIN: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         idx_q     <= '0;
         sel_in_q  <= '0;
         sel_out_q <= '0;
         ctrl_q    <= '0;
         err_ovf_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         sel_in_q  <= sel_in_d;
         sel_out_q <= sel_out_d;
         ctrl_q    <= ctrl_d;
         err_ovf_q <= err_ovf_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   assign ctrl_out_o = ctrl_q;
   assign sel_in_o   = sel_in_q;
   assign sel_out_o  = sel_out_q;
   assign count_o    = count_q;
   assign err_ovf_o  = err_ovf_q;
   assign err_tmo_o  = err_tmo_q;
   assign lcd_go_o   = (state_q == ST_ISSUE);
   assign done_o     = (state_q == ST_FIN);
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_lcd_cmd_sched
// Bench for lcd_cmd_sched with a behavioural command bank, a driver model
// that answers lcd_go with a busy window, a queue-based reference model of
// the command list, and a monitor that scores every lcd_go / done pulse and
// every queued register check.
// ----------------------------------------------------------------------------
module tb_lcd_cmd_sched;

   localparam int SLOTS = 8;
   localparam int SEL_W = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en_i;
   logic [23:0] wr_data_i;
   logic        clr_i;
   logic        start_i;
   logic        abort_i;
   logic [7:0]  lcd_status_i;
   logic [23:0] ctrl_out_o;
   logic [2:0]  sel_in_o;
   logic [2:0]  sel_out_o;
   logic        lcd_go_o;
   logic [3:0]  count_o;
   logic        busy_o;
   logic        done_o;
   logic        err_ovf_o;
   logic        err_tmo_o;

   always #5 clk = ~clk;

   lcd_cmd_sched #(
      .SLOTS    (SLOTS),
      .SEL_W    (SEL_W),
      .BUSY_BIT (0),
      .TMO_W    (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (wr_en_i),
      .wr_data_i    (wr_data_i),
      .clr_i        (clr_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .lcd_status_i (lcd_status_i),
      .ctrl_out_o   (ctrl_out_o),
      .sel_in_o     (sel_in_o),
      .sel_out_o    (sel_out_o),
      .lcd_go_o     (lcd_go_o),
      .count_o      (count_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_ovf_o    (err_ovf_o),
      .err_tmo_o    (err_tmo_o)
   );

   // Command bank: written every clock, registered read
   logic [23:0] bank_mem [SLOTS];
   logic [23:0] bank_q;
   always @(posedge clk) begin
      bank_mem[sel_in_o] <= ctrl_out_o;
      bank_q             <= bank_mem[sel_out_o];
   end

   // Driver model: busy rises drv_d cycles after lcd_go, stays drv_h cycles.
   // Non-busy status bits carry noise.
   int drv_d  = 2;
   int drv_h  = 2;
   bit drv_en = 1'b1;
   initial begin
      lcd_status_i = 8'h00;
      forever begin
         @(negedge clk);
         if (lcd_go_o && drv_en) begin
            repeat (drv_d) @(negedge clk);
            lcd_status_i = 8'($urandom) | 8'h01;
            repeat (drv_h) @(negedge clk);
            lcd_status_i = 8'($urandom) & 8'hFE;
         end
      end
   end

   // Scoreboard queues
   logic [31:0] go_q[$];
   bit          done_q[$];
   string       chk_name_q[$];
   logic [31:0] chk_act_q[$];
   logic [31:0] chk_exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          fin_req  = 1'b0;
   bit          mon_fin  = 1'b0;

   // Reference model of the command list
   logic [23:0] mdl_slots[$];
   bit          mdl_ovf = 1'b0;
   bit          mdl_tmo = 1'b0;
   logic [23:0] mdl_last_word = '0;
   logic [2:0]  mdl_last_sel = '0;
   int          last_span = 0;
   int          last_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_name_q.push_back(name);
      chk_act_q.push_back(act);
      chk_exp_q.push_back(exp);
   endtask

   // Monitor
   initial begin
      string       nm;
      logic [31:0] a;
      logic [31:0] e;
      bit          ed;
      forever begin
         @(negedge clk);
         while (chk_name_q.size() != 0) begin
            nm = chk_name_q.pop_front();
            a  = chk_act_q.pop_front();
            e  = chk_exp_q.pop_front();
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s: got %0h, expected %0h", nm, a, e);
            end
         end
         if (lcd_go_o === 1'b1) begin
            n_checks++;
            a = {5'b0, sel_out_o, bank_q};
            if (go_q.size() == 0) begin
               n_fail++;
               $display("FAIL lcd_go_unexpected: got sel/word %0h, expected no lcd_go", a);
            end else begin
               e = go_q.pop_front();
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL lcd_go_cmd: got sel/word %0h, expected %0h", a, e);
               end else begin
                  $display("lcd_go slot %0d word %06h", sel_out_o, bank_q);
               end
            end
         end
         if (done_o === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
               n_fail++;
               $display("FAIL done_unexpected: got done=1, expected 0");
            end else begin
               ed = done_q.pop_front();
               if (err_tmo_o !== ed) begin
                  n_fail++;
                  $display("FAIL done_err_tmo: got %0b, expected %0b", err_tmo_o, ed);
               end else begin
                  $display("done err_tmo=%0b", err_tmo_o);
               end
            end
         end
         if (fin_req && !mon_fin) begin
            n_checks++;
            if (go_q.size() != 0 || done_q.size() != 0) begin
               n_fail++;
               $display("FAIL leftover_expect: got %0d lcd_go and %0d done outstanding, expected 0",
                        go_q.size(), done_q.size());
            end
            mon_fin = 1'b1;
         end
      end
   end

   task automatic write_word(input logic [23:0] w);
      wr_en_i   = 1'b1;
      wr_data_i = w;
      @(negedge clk);
      wr_en_i = 1'b0;
      if (mdl_slots.size() < SLOTS) begin
         mdl_last_sel  = 3'(mdl_slots.size());
         mdl_last_word = w;
         mdl_slots.push_back(w);
      end else begin
         mdl_ovf = 1'b1;
      end
      $display("write %06h count=%0d", w, count_o);
      chk("wr_ctrl_out", 32'(ctrl_out_o), 32'(mdl_last_word));
      chk("wr_sel_in", 32'(sel_in_o), 32'(mdl_last_sel));
      chk("wr_count", 32'(count_o), 32'(mdl_slots.size()));
      chk("wr_err_ovf", 32'(err_ovf_o), 32'(mdl_ovf));
   endtask

   task automatic do_clr();
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
      mdl_slots.delete();
      mdl_ovf = 1'b0;
      mdl_tmo = 1'b0;
      $display("clr count=%0d", count_o);
      chk("clr_count", 32'(count_o), 32'd0);
      chk("clr_err_ovf", 32'(err_ovf_o), 32'd0);
      chk("clr_err_tmo", 32'(err_tmo_o), 32'd0);
   endtask

   // Replay the list; wiggle drives ignored host traffic while busy
   task automatic run(input bit wiggle);
      int  cycles;
      int  go_at;
      bit  got_done;
      if (mdl_slots.size() > 0 && !drv_en) begin
         go_q.push_back({5'b0, 3'd0, mdl_slots[0]});
         mdl_tmo = 1'b1;
      end else begin
         for (int i = 0; i < mdl_slots.size(); i++)
            go_q.push_back({5'b0, 3'(i), mdl_slots[i]});
      end
      done_q.push_back(mdl_tmo);
      start_i = 1'b1;
      @(negedge clk);
      start_i  = 1'b0;
      cycles   = 0;
      go_at    = 0;
      got_done = 1'b0;
      while (cycles < 5000) begin
         if (lcd_go_o) go_at = cycles;
         if (done_o) begin
            got_done = 1'b1;
            break;
         end
         if (wiggle) begin
            wr_en_i   = 1'($urandom);
            wr_data_i = 24'($urandom);
            clr_i     = ($urandom_range(0, 3) == 0);
         end
         @(negedge clk);
         cycles++;
      end
      wr_en_i     = 1'b0;
      clr_i       = 1'b0;
      last_span   = cycles - go_at;
      last_cycles = cycles;
      $display("run slots=%0d cycles=%0d done=%0b", mdl_slots.size(), cycles, got_done);
      chk("run_done_seen", 32'(got_done), 32'd1);
      @(negedge clk);
      chk("run_idle_after", 32'(busy_o), 32'd0);
      chk("run_count_kept", 32'(count_o), 32'(mdl_slots.size()));
      chk("run_err_ovf", 32'(err_ovf_o), 32'(mdl_ovf));
      chk("run_err_tmo", 32'(err_tmo_o), 32'(mdl_tmo));
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ngo;
      int cyc;
      int n;
      rst_n     = 1'b0;
      wr_en_i   = 1'b0;
      wr_data_i = '0;
      clr_i     = 1'b0;
      start_i   = 1'b0;
      abort_i   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl_out", 32'(ctrl_out_o), 32'd0);
      chk("rst_flags", 32'({sel_in_o, sel_out_o, lcd_go_o, count_o, busy_o, done_o,
                            err_ovf_o, err_tmo_o}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three known words, replayed with a 2-cycle busy delay
      write_word(24'h010203);
      write_word(24'h040506);
      write_word(24'h070809);
      drv_d = 2;
      drv_h = 2;
      run(1'b0);

      // Fill past capacity, replay all eight, then clear
      do_clr();
      for (int i = 0; i < 9; i++) write_word(24'($urandom));
      run(1'b0);
      do_clr();

      // Empty list: done almost at once, no lcd_go
      run(1'b1);
      chk("empty_done_prompt", 32'(last_cycles <= 1), 32'd1);

      // Randomised lists, driver timing and ignored host traffic
      for (int r = 0; r < 6; r++) begin
         do_clr();
         n = $urandom_range(1, SLOTS);
         for (int i = 0; i < n; i++) write_word(24'($urandom));
         drv_d = $urandom_range(1, 3);
         drv_h = $urandom_range(1, 3);
         run(1'b1);
      end

      // Driver never answers: timeout after 2**10-1 waiting cycles
      do_clr();
      write_word(24'hABCDEF);
      write_word(24'h123456);
      drv_en = 1'b0;
      run(1'b1);
      chk("tmo_latency", 32'(last_span >= 1023 && last_span <= 1026), 32'd1);
      drv_en = 1'b1;
      do_clr();

      // Abort inside WAIT_DONE of slot 1
      write_word(24'h010203);
      write_word(24'h040506);
      write_word(24'h070809);
      drv_d = 2;
      drv_h = 8;
      go_q.push_back({5'b0, 3'd0, mdl_slots[0]});
      go_q.push_back({5'b0, 3'd1, mdl_slots[1]});
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      ngo = 0;
      cyc = 0;
      while (cyc < 200) begin
         if (lcd_go_o) ngo++;
         if (ngo == 2) break;
         @(negedge clk);
         cyc++;
      end
      chk("abort_reached_slot1", 32'(ngo), 32'd2);
      repeat (drv_d + 2) @(negedge clk);
      chk("abort_busy_before", 32'(busy_o), 32'd1);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      $display("abort busy=%0b count=%0d", busy_o, count_o);
      chk("abort_idle", 32'(busy_o), 32'd0);
      chk("abort_count", 32'(count_o), 32'd3);
      chk("abort_flags", 32'({err_ovf_o, err_tmo_o}), 32'd0);
      repeat (15) @(negedge clk);
      chk("abort_stays_idle", 32'(busy_o), 32'd0);

      // List survives the abort
      drv_h = 2;
      run(1'b0);

      fin_req = 1'b1;
      for (int k = 0; k < 10 && !mon_fin; k++) @(negedge clk);
      if (!mon_fin) begin
         n_checks++;
         n_fail++;
         $display("FAIL monitor_final: got no final scoring, expected it");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
